imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Upstream feeder of MipsCPU: receives a framed byte stream (debug UART/host) and writes 32-bit
//  words into instruction memory from word address 0. Holds the CPU in reset until a complete,
//  checksum-valid image is loaded, then releases it. On any framing error the CPU stays in reset.
//  Frame: MAGIC, N[15:8], N[7:0], 4*N word bytes (big-endian), CHK (XOR of all 4*N word bytes).
// PARAMETERS
//  ADDR_W   8       imem word-address width; capacity 2**ADDR_W words
//  TIMEOUT  1024    max idle cycles between bytes inside a frame before error
//  MAGIC    8'hA5   frame start byte
// PORTS
//  clock       in   1       single clock, all logic on rising edge
//  reset       in   1       synchronous, active-high
//  in_valid    in   1       byte stream valid
//  in_data     in   8       byte stream data
//  in_ready    out  1       loader accepts byte; transfer = in_valid & in_ready
//  imem_we     out  1       imem write strobe, one cycle per word
//  imem_addr   out  ADDR_W  imem word address
//  imem_wdata  out  32      imem write data
//  cpu_reset   out  1       active-high hold for MipsCPU (inverted at top level if CPU needs low)
//  done        out  1       image loaded, CPU running
//  error       out  1       frame rejected; sticky until reset
// BEHAVIOUR
//  Reset (sync, any state): state=IDLE, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0,
//   cpu_reset=1, done=0, error=0; word/byte counters, checksum, timeout counter cleared.
//   Words already written are not undone.
//  States: IDLE -> CNT_HI -> CNT_LO -> LOAD -> CHK -> RUN; any framing fault -> ERR.
//  IDLE: byte==MAGIC -> CNT_HI; other bytes accepted and discarded.
//  CNT_HI/CNT_LO: latch N (16 bit). After CNT_LO: N==0 or N>2**ADDR_W -> ERR, else LOAD.
//  LOAD: shift bytes MSB-first into 32-bit word; XOR each byte into checksum. The cycle after the
//   4th byte is accepted: imem_we=1, imem_addr=word index, imem_wdata=word (latency 1 cycle).
//   Word index increments after each write; after word N-1 -> CHK. Back-to-back bytes every
//   cycle must be sustained (no bubbles inserted; in_ready stays 1 in LOAD).
//  CHK: byte==checksum -> RUN, else ERR.
//  RUN: in_ready=0, cpu_reset=0, done=1 (both change in the cycle after CHK byte accepted).
//  ERR: in_ready=0, cpu_reset=1, error=1, done=0; exit only by reset.
//  Timeout: in CNT_HI..CHK, counter increments each cycle with no transfer, clears on transfer;
//   reaching TIMEOUT -> ERR. Counter inactive in IDLE/RUN/ERR.
//  imem_we never asserts outside LOAD-derived writes; at most N writes per frame.
//  Index arithmetic: word index ADDR_W+1 bits wide so N=2**ADDR_W is legal without wrap.
// STRUCTURE
//  Shared include mips_defs.vh: state encodings, MAGIC default, frame header length constant.
//  One sub-module: word_assembler (byte shift-in, byte counter 0..3, word_valid pulse, XOR
//   checksum, clear input). FSM, timeout and imem interface stay in imem_boot_loader.
// TESTING
//  1 A5,00,02,20,08,00,05,20,09,00,0A,0E -> writes (0,0x20080005),(1,0x2009000A); done=1,
//    cpu_reset=0 one cycle after CHK byte; in_ready=0 afterwards.
//  2 Same frame, CHK=0x0F -> error=1, cpu_reset stays 1, done=0, in_ready=0.
//  3 Bytes 00,FF,5A then frame of test 1 -> leading bytes discarded, result identical to test 1.
//  4 A5,00,00 -> ERR after CNT_LO; ADDR_W=8 with N=0x0101 -> ERR, no imem writes.
//  5 Test 1 frame with in_valid low TIMEOUT-1 cycles mid-word -> completes; TIMEOUT cycles -> ERR.
//  6 reset pulsed after 5 word bytes -> IDLE, all outputs at reset values; test 1 frame then
//    loads correctly; random in_valid gaps (<TIMEOUT) give same writes as back-to-back.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding, default frame start byte and the running checksum helper.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_HI = 3'd1,
        ST_CNT_LO = 3'd2,
        ST_LOAD   = 3'd3,
        ST_CHK    = 3'd4,
        ST_RUN    = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    // Frame checksum is a plain XOR of every word byte.
    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data);
        return chk ^ data;
    endfunction

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Collects word bytes MSB-first into 32-bit words and keeps the running
// XOR checksum of every byte seen since the last clear.
module imem_boot_loader_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        word_valid_o,
    output logic [31:0] word_o,
    output logic [7:0]  chk_o
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  chk_q, chk_d;

    // Next-state for shift register, byte counter and checksum.
    always_comb begin
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        chk_d      = chk_q;
        if (clear_i) begin
            shift_d    = 24'd0;
            byte_cnt_d = 2'd0;
            chk_d      = 8'd0;
        end else if (byte_valid_i) begin
            shift_d    = {shift_q[15:0], byte_data_i};
            byte_cnt_d = byte_cnt_q + 2'd1;
            chk_d      = chk_update(chk_q, byte_data_i);
        end else begin
            shift_d    = shift_q;
            byte_cnt_d = byte_cnt_q;
            chk_d      = chk_q;
        end
    end

    // The fourth byte completes a word; the word is the three held bytes plus the incoming one.
    assign word_valid_o = byte_valid_i && !clear_i && (byte_cnt_q == 2'd3);
    assign word_o       = {shift_q, byte_data_i};
    assign chk_o        = chk_q;

    // Assembler state registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q    <= 24'd0;
            byte_cnt_q <= 2'd0;
            chk_q      <= 8'd0;
        end else begin
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            chk_q      <= chk_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader in front of the MIPS core: parses a framed byte stream,
// writes the image into instruction memory from word 0 and releases the
// CPU reset only after a checksum-valid frame has been fully loaded.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 1024,
    parameter logic [7:0]  MAGIC   = MAGIC_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    // Word index carries one extra bit so a full 2**ADDR_W image never wraps.
    localparam int unsigned IDX_W    = ADDR_W + 1;
    localparam int unsigned TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

    state_e            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TO_W-1:0]   to_q, to_d;

    logic              in_ready_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              cpu_reset_q;
    logic              done_q;
    logic              error_q;

    logic              fire_s;
    logic              load_byte_s;
    logic              timing_s;
    logic [15:0]       n_full_s;
    logic [16:0]       idx_next_s;
    logic              last_word_s;
    logic              asm_valid_s;
    logic [31:0]       asm_word_s;
    logic [7:0]        asm_chk_s;

    assign fire_s      = in_valid && in_ready_q;
    assign load_byte_s = fire_s && (state_q == ST_LOAD);
    assign timing_s    = (state_q == ST_CNT_HI) || (state_q == ST_CNT_LO) ||
                         (state_q == ST_LOAD)   || (state_q == ST_CHK);
    assign n_full_s    = {n_q[15:8], in_data};
    assign idx_next_s  = 17'(idx_q) + 17'd1;
    assign last_word_s = (idx_next_s == {1'b0, n_q});

    imem_boot_loader_word_assembler u_asm (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (state_q == ST_IDLE),
        .byte_valid_i (load_byte_s),
        .byte_data_i  (in_data),
        .word_valid_o (asm_valid_s),
        .word_o       (asm_word_s),
        .chk_o        (asm_chk_s)
    );

    // Frame parser next-state, word index and inter-byte timeout.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        to_d    = to_q;

        case (state_q)
            ST_IDLE: begin
                if (fire_s && (in_data == MAGIC)) begin
                    state_d = ST_CNT_HI;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CNT_HI: begin
                if (fire_s) begin
                    n_d     = {in_data, 8'd0};
                    state_d = ST_CNT_LO;
                end else begin
                    state_d = ST_CNT_HI;
                end
            end
            ST_CNT_LO: begin
                if (fire_s) begin
                    n_d = n_full_s;
                    if ((n_full_s == 16'd0) || ({1'b0, n_full_s} > CAPACITY)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_CNT_LO;
                end
            end
            ST_LOAD: begin
                if (asm_valid_s) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (last_word_s) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_CHK: begin
                if (fire_s) begin
                    if (in_data == asm_chk_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_CHK;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase

        // Idle cycles inside a frame are counted; the TIMEOUT-th one aborts the frame.
        if (timing_s) begin
            if (fire_s) begin
                to_d = '0;
            end else begin
                to_d = to_q + TO_W'(1);
                if (to_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = state_d;
                end
            end
        end else begin
            to_d = '0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            n_q          <= 16'd0;
            idx_q        <= '0;
            to_q         <= '0;
            in_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            to_q         <= to_d;
            in_ready_q   <= (state_d != ST_RUN) && (state_d != ST_ERR);
            cpu_reset_q  <= (state_d != ST_RUN);
            done_q       <= (state_d == ST_RUN);
            error_q      <= (state_d == ST_ERR);
            imem_we_q    <= asm_valid_s;
            if (asm_valid_s) begin
                imem_addr_q  <= idx_q[ADDR_W-1:0];
                imem_wdata_q <= asm_word_s;
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed and randomized frames checked
// against a frame-level reference model of the loader's byte protocol.
module tb_imem_boot_loader;

    localparam int         ADDR_W  = 8;
    localparam int         TIMEOUT = 1024;
    localparam logic [7:0] MAGIC   = 8'hA5;
    localparam logic [7:0] T1 [12] = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00,
                                       8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    int vec_cnt = 0;
    int mis_cnt = 0;

    logic [7:0]  stim[$];
    logic [39:0] exp_wr[$];
    logic [39:0] got_wr[$];
    int          exp_status;   // 0 frame incomplete, 1 loaded, 2 rejected

    always #5 clock = ~clock;

    imem_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .MAGIC(MAGIC)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    // Capture every instruction-memory write away from the active edge.
    always @(negedge clock) begin
        if (imem_we === 1'b1) got_wr.push_back({imem_addr, imem_wdata});
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vec_cnt++;
        assert (obs === expv) else begin
            mis_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // {in_ready, cpu_reset, done, error} for each frame outcome.
    function automatic logic [3:0] status_exp(input int s);
        if (s == 1) return 4'b0010;
        if (s == 2) return 4'b0101;
        return 4'b1100;
    endfunction

    // Parses the byte stream the way the frame format defines it.
    function automatic void run_model();
        int          i;
        int          n;
        logic [7:0]  chk;
        logic [31:0] w;
        exp_wr.delete();
        exp_status = 0;
        i = 0;
        while (i < stim.size() && stim[i] != MAGIC) i++;
        if (i + 3 > stim.size()) return;
        n = {stim[i+1], stim[i+2]};
        i += 3;
        if (n == 0 || n > (1 << ADDR_W)) begin
            exp_status = 2;
            return;
        end
        chk = 8'h00;
        for (int k = 0; k < n; k++) begin
            if (i + 4 > stim.size()) return;
            w = {stim[i], stim[i+1], stim[i+2], stim[i+3]};
            chk = chk ^ stim[i] ^ stim[i+1] ^ stim[i+2] ^ stim[i+3];
            exp_wr.push_back({8'(k), w});
            i += 4;
        end
        if (i >= stim.size()) return;
        exp_status = (stim[i] == chk) ? 1 : 2;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        got_wr.delete();
        check({tag, "_ctl"}, {in_ready, imem_we, cpu_reset, done, error}, 5'b10100);
        check({tag, "_addr"}, imem_addr, 0);
        check({tag, "_wdata"}, imem_wdata, 0);
    endtask

    task automatic check_result(input string tag);
        check({tag, "_nwr"}, got_wr.size(), exp_wr.size());
        for (int k = 0; k < got_wr.size() && k < exp_wr.size(); k++)
            check($sformatf("%s_wr%0d", tag, k), got_wr[k], exp_wr[k]);
        check({tag, "_status"}, {in_ready, cpu_reset, done, error}, status_exp(exp_status));
    endtask

    // Sends stim with random gaps up to gap_max, except a fixed gap before byte gap_at.
    task automatic run_stream(input string tag, input int gap_max, input int gap_at, input int gap_len);
        int g;
        run_model();
        for (int j = 0; j < stim.size(); j++) begin
            if (j == gap_at) g = gap_len;
            else if (gap_max > 0) g = $urandom_range(gap_max, 0);
            else g = 0;
            send_byte(stim[j], g);
        end
        idle(3);
        check_result(tag);
    endtask

    task automatic load_t1();
        stim.delete();
        foreach (T1[j]) stim.push_back(T1[j]);
    endtask

    // Random frame: n words, optionally corrupted checksum.
    task automatic add_frame(input int n, input bit corrupt);
        logic [7:0] chk;
        logic [7:0] b;
        chk = 8'h00;
        stim.push_back(MAGIC);
        stim.push_back(8'(n >> 8));
        stim.push_back(8'(n));
        for (int k = 0; k < 4 * n; k++) begin
            b = 8'($urandom);
            chk = chk ^ b;
            stim.push_back(b);
        end
        stim.push_back(corrupt ? (chk ^ 8'(1 + $urandom_range(254, 0))) : chk);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        do_reset("rst0");

        // Reference frame, with exact release latency on the checksum byte.
        load_t1();
        run_model();
        for (int j = 0; j < stim.size() - 1; j++) send_byte(stim[j], 0);
        send_byte(stim[stim.size()-1], 0);
        check("t1_before_chk", {in_ready, cpu_reset, done, error}, 4'b1100);
        @(negedge clock);
        in_valid = 1'b0;
        check("t1_after_chk", {in_ready, cpu_reset, done, error}, 4'b0010);
        idle(2);
        check_result("t1");

        // Bad checksum.
        do_reset("rst2");
        load_t1();
        stim[11] = 8'h0F;
        run_stream("t2", 0, -1, 0);

        // Leading garbage is discarded.
        do_reset("rst3");
        stim = '{8'h00, 8'hFF, 8'h5A};
        foreach (T1[j]) stim.push_back(T1[j]);
        run_stream("t3", 0, -1, 0);

        // Zero and oversize word counts.
        do_reset("rst4a");
        stim = '{8'hA5, 8'h00, 8'h00};
        run_stream("t4a", 0, -1, 0);
        do_reset("rst4b");
        stim = '{8'hA5, 8'h01, 8'h01};
        run_stream("t4b", 0, -1, 0);

        // Full-capacity image is legal.
        do_reset("rst4c");
        stim.delete();
        add_frame(1 << ADDR_W, 1'b0);
        run_stream("t4c", 0, -1, 0);

        // Longest tolerated gap mid-word, then one cycle too long.
        do_reset("rst5a");
        load_t1();
        run_stream("t5a", 0, 5, TIMEOUT - 1);
        do_reset("rst5b");
        for (int j = 0; j < 5; j++) send_byte(T1[j], 0);
        idle(TIMEOUT);
        check("t5b_edge", {in_ready, cpu_reset, done, error}, 4'b1100);
        idle(1);
        check("t5b_timeout", {in_ready, cpu_reset, done, error}, 4'b0101);

        // Reset in the middle of a frame, then a clean reload with random gaps.
        do_reset("rst6");
        for (int j = 0; j < 8; j++) send_byte(T1[j], 0);
        idle(2);
        do_reset("t6_reset");
        load_t1();
        run_stream("t6", 12, -1, 0);

        // Randomized frames with garbage, gaps and occasional bad checksums.
        for (int r = 0; r < 8; r++) begin
            do_reset($sformatf("rstr%0d", r));
            stim.delete();
            repeat ($urandom_range(3, 0)) stim.push_back(8'($urandom_range(8'hA4, 0)));
            add_frame($urandom_range(8, 1), ($urandom_range(3, 0) == 0));
            run_stream($sformatf("rnd%0d", r), (r % 2 == 0) ? 0 : 20, -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
